instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/tiny16_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/instr_fetch.sv | 126 ++++++++++++
 tb/tb_instr_fetch.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny16_pkg.sv
// Shared definitions for the tiny16 core: word width, reset vector and the
// fetch-unit state encoding.
package tiny16_pkg;

    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] RESET_VECTOR = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction queue with flush; count is registered so a pushed
// entry becomes visible one cycle after the push.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    // Guard against overflow/underflow even though the fetch unit never asks for it.
    assign push_ok = push_i && ((count_q != FULL_CNT) || pop_i);
    assign pop_ok  = pop_i && (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
            else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory requester feeding a small
// queue, with redirect flush that drops a stale in-flight response.
module instr_fetch
    import tiny16_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [WORD_W-1:0] RESET_PC = RESET_VECTOR
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_rd,
    output logic [WORD_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] last_instr_q, last_pc_q;
    logic [CW-1:0]     count;
    logic [CW:0]       occ_next;
    logic              push, pop, issue_ok;
    fetch_entry_t      wr_entry, head;

    // In REQ fetch_pc is the outstanding address; in IDLE/DROP it is the next one to issue.
    assign push        = (state_q == REQ) && mem_ack && !redirect;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready && !redirect;
    assign occ_next    = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
    assign issue_ok    = !halt && (occ_next < DEPTH_W);

    assign wr_entry.word = mem_rdata;
    assign wr_entry.pc   = addr_q;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .clear_i (redirect),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .count_o (count)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    if (!halt) begin
                        state_d = REQ;
                        addr_d  = redirect_pc;
                    end
                end else if (issue_ok) begin
                    state_d = REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    if (!mem_ack)   state_d = DROP;
                    else if (!halt) addr_d  = redirect_pc;
                    else            state_d = IDLE;
                end else if (mem_ack) begin
                    fetch_pc_d = fetch_pc_q + 1'b1;
                    if (issue_ok) addr_d  = fetch_pc_q + 1'b1;
                    else          state_d = IDLE;
                end
            end
            DROP: begin
                // Queue is empty here, so only halt can hold off the restart.
                if (redirect) fetch_pc_d = redirect_pc;
                if (mem_ack) begin
                    if (!halt) begin
                        state_d = REQ;
                        addr_d  = redirect ? redirect_pc : fetch_pc_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            addr_q       <= '0;
            last_instr_q <= '0;
            last_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            addr_q       <= addr_d;
            last_instr_q <= instr;
            last_pc_q    <= instr_pc;
        end
    end

    assign mem_rd   = (state_q != IDLE);
    assign mem_addr = addr_q;
    assign instr    = instr_valid ? head.word : last_instr_q;
    assign instr_pc = instr_valid ? head.pc   : last_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run checked
// against a queue-level model of the fetch/flush rules.
module tb_instr_fetch;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd, mem_ack, instr_valid, instr_ready, redirect, halt;
    logic [15:0] mem_addr, mem_rdata, instr, instr_pc, redirect_pc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
    );

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic idle_inputs();
        mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Zero-wait memory: acknowledge whatever is being requested this cycle.
    task automatic respond(input bit en);
        mem_ack   = en && mem_rd;
        mem_rdata = memf(mem_addr);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; idle_inputs(); mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL reset_rd: got %b want 0", mem_rd); end
        n_vec++; if (mem_addr !== 16'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_vec++; if (instr !== 16'h0 || instr_pc !== 16'h0) begin n_err++; $display("FAIL reset_instr: got %h/%h want 0000/0000", instr, instr_pc); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (mem_rd !== 1'b1 || mem_addr !== RESET_PC) begin n_err++; $display("FAIL first_req: got %b/%h want 1/%h", mem_rd, mem_addr, RESET_PC); end
        mem_ack = 1'b0;
        @(negedge clk);
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL idle_ack_ignored: got valid %b want 0", instr_valid); end
        n_vec++; if (mem_rd !== 1'b1 || mem_addr !== RESET_PC) begin n_err++; $display("FAIL req_stable: got %b/%h want 1/%h", mem_rd, mem_addr, RESET_PC); end
        rst = 1'b0; mem_ack = 1'b1;
        #1;
        n_vec++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL async_reset: got %b want 0", mem_rd); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        n_vec++; if (mem_rd !== 1'b1 || mem_addr !== RESET_PC) begin n_err++; $display("FAIL restart_req: got %b/%h want 1/%h", mem_rd, mem_addr, RESET_PC); end
        @(negedge clk);
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL late_ack_dropped: got valid %b want 0", instr_valid); end
    endtask

    task automatic test_stream();
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_vec++; if (mem_rd !== 1'b1 || mem_addr !== 16'(i)) begin n_err++; $display("FAIL stream_addr: got %b/%h want 1/%h", mem_rd, mem_addr, 16'(i)); end
            if (i == 0) begin
                n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL stream_latency: got valid %b want 0", instr_valid); end
            end else begin
                n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 16'(i-1) || instr !== memf(16'(i-1)))
                    begin n_err++; $display("FAIL stream_instr: got %b/%h/%h want 1/%h/%h", instr_valid, instr_pc, instr, 16'(i-1), memf(16'(i-1))); end
            end
            respond(1'b1);
        end
    endtask

    task automatic test_backpressure();
        int reqs = 0;
        int got = 1;
        bit resumed = 1'b0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mem_rd) reqs++;
            respond(1'b1);
        end
        n_vec++; if (reqs != DEPTH) begin n_err++; $display("FAIL full_reqs: got %0d want %0d", reqs, DEPTH); end
        n_vec++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL full_no_rd: got %b want 0", mem_rd); end
        n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0) begin n_err++; $display("FAIL full_head: got %b/%h want 1/0000", instr_valid, instr_pc); end
        instr_ready = 1'b1;
        for (int c = 0; c < 30 && got < 8; c++) begin
            @(negedge clk);
            if (mem_rd) resumed = 1'b1;
            if (instr_valid) begin
                n_vec++; if (instr_pc !== 16'(got) || instr !== memf(16'(got)))
                    begin n_err++; $display("FAIL drain_order: got %h/%h want %h/%h", instr_pc, instr, 16'(got), memf(16'(got))); end
                got++;
            end
            respond(1'b1);
        end
        n_vec++; if (got != 8 || !resumed) begin n_err++; $display("FAIL drain_resume: got %0d entries resumed %b want 8 1", got, resumed); end
    endtask

    task automatic test_redirect_drop();
        bit found = 1'b0;
        do_reset();
        instr_ready = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (mem_rd && mem_addr == 16'h0005) found = 1'b1;
            else respond(1'b1);
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL drop_reach5: got found %b want 1", found); end
        mem_ack = 1'b0; redirect = 1'b1; redirect_pc = 16'h0100;
        @(negedge clk);
        redirect = 1'b0;
        n_vec++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0005) begin n_err++; $display("FAIL drop_hold1: got %b/%h want 1/0005", mem_rd, mem_addr); end
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL drop_flush: got valid %b want 0", instr_valid); end
        @(negedge clk);
        n_vec++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0005) begin n_err++; $display("FAIL drop_hold2: got %b/%h want 1/0005", mem_rd, mem_addr); end
        mem_ack = 1'b1; mem_rdata = memf(16'h0005);
        @(negedge clk);
        n_vec++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0100) begin n_err++; $display("FAIL drop_restart: got %b/%h want 1/0100", mem_rd, mem_addr); end
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL drop_discard: got valid %b pc %h want 0", instr_valid, instr_pc); end
        respond(1'b1);
        @(negedge clk);
        n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0100 || instr !== memf(16'h0100))
            begin n_err++; $display("FAIL drop_newhead: got %b/%h/%h want 1/0100/%h", instr_valid, instr_pc, instr, memf(16'h0100)); end
    endtask

    task automatic test_redirect_ack();
        bit found = 1'b0;
        do_reset();
        instr_ready = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (mem_rd && mem_addr == 16'h0003) found = 1'b1;
            else respond(1'b1);
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL rack_reach3: got found %b want 1", found); end
        respond(1'b1); redirect = 1'b1; redirect_pc = 16'h0200;
        @(negedge clk);
        redirect = 1'b0;
        n_vec++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0200) begin n_err++; $display("FAIL rack_addr: got %b/%h want 1/0200", mem_rd, mem_addr); end
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rack_flush: got valid %b want 0", instr_valid); end
        respond(1'b1);
        @(negedge clk);
        n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0200 || mem_addr !== 16'h0201)
            begin n_err++; $display("FAIL rack_next: got %b/%h addr %h want 1/0200 addr 0201", instr_valid, instr_pc, mem_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        instr_ready = 1'b1;
        @(negedge clk);
        respond(1'b1); redirect = 1'b1; redirect_pc = 16'hFFFF;
        @(negedge clk);
        redirect = 1'b0;
        n_vec++; if (mem_rd !== 1'b1 || mem_addr !== 16'hFFFF) begin n_err++; $display("FAIL wrap_ffff: got %b/%h want 1/ffff", mem_rd, mem_addr); end
        respond(1'b1);
        @(negedge clk);
        n_vec++; if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL wrap_addr0: got %h want 0000", mem_addr); end
        n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 16'hFFFF || instr !== memf(16'hFFFF))
            begin n_err++; $display("FAIL wrap_pc_ffff: got %b/%h/%h want 1/ffff/%h", instr_valid, instr_pc, instr, memf(16'hFFFF)); end
        respond(1'b1);
        @(negedge clk);
        n_vec++; if (instr_pc !== 16'h0000 || instr !== memf(16'h0000) || mem_addr !== 16'h0001)
            begin n_err++; $display("FAIL wrap_pc_0: got %h/%h addr %h want 0000/%h addr 0001", instr_pc, instr, mem_addr, memf(16'h0000)); end
    endtask

    task automatic test_halt();
        int rd_seen = 0;
        do_reset();
        @(negedge clk);
        n_vec++; if (mem_rd !== 1'b1 || mem_addr !== RESET_PC) begin n_err++; $display("FAIL halt_req: got %b/%h want 1/%h", mem_rd, mem_addr, RESET_PC); end
        mem_ack = 1'b0; halt = 1'b1;
        @(negedge clk);
        n_vec++; if (mem_rd !== 1'b1) begin n_err++; $display("FAIL halt_keep: got %b want 1", mem_rd); end
        mem_ack = 1'b1; mem_rdata = memf(RESET_PC);
        @(negedge clk);
        mem_ack = 1'b0;
        n_vec++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL halt_stop: got %b want 0", mem_rd); end
        n_vec++; if (instr_valid !== 1'b1 || instr_pc !== RESET_PC || instr !== memf(RESET_PC))
            begin n_err++; $display("FAIL halt_queued: got %b/%h/%h want 1/%h/%h", instr_valid, instr_pc, instr, RESET_PC, memf(RESET_PC)); end
        repeat (4) begin
            @(negedge clk);
            if (mem_rd) rd_seen++;
        end
        n_vec++; if (rd_seen != 0) begin n_err++; $display("FAIL halt_idle: got %0d rd cycles want 0", rd_seen); end
        halt = 1'b0;
        @(negedge clk);
        n_vec++; if (mem_rd !== 1'b1 || mem_addr !== RESET_PC + 16'h1) begin n_err++; $display("FAIL halt_resume: got %b/%h want 1/%h", mem_rd, mem_addr, RESET_PC + 16'h1); end
    endtask

    task automatic test_random();
        logic [31:0] mq[$];
        logic [15:0] issue_ptr = RESET_PC;
        logic [15:0] last_instr = '0, last_pc = '0, prev_addr = '0;
        bit prev_rd = 1'b0, prev_ack = 1'b0, prev_halt = 1'b0, stale = 1'b0, exp_rd;
        int wait_left = 0;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            n_vec++; if (instr_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd_valid: cyc %0d got %b want %b", cyc, instr_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                n_vec++; if (instr_pc !== mq[0][15:0] || instr !== mq[0][31:16])
                    begin n_err++; $display("FAIL rnd_head: cyc %0d got %h/%h want %h/%h", cyc, instr_pc, instr, mq[0][15:0], mq[0][31:16]); end
            end else begin
                n_vec++; if (instr_pc !== last_pc || instr !== last_instr)
                    begin n_err++; $display("FAIL rnd_hold: cyc %0d got %h/%h want %h/%h", cyc, instr_pc, instr, last_pc, last_instr); end
            end
            last_instr = instr; last_pc = instr_pc;
            if (prev_rd && !prev_ack) begin
                n_vec++; if (mem_rd !== 1'b1 || mem_addr !== prev_addr)
                    begin n_err++; $display("FAIL rnd_stable: cyc %0d got %b/%h want 1/%h", cyc, mem_rd, mem_addr, prev_addr); end
            end else begin
                exp_rd = !prev_halt && (mq.size() < DEPTH);
                n_vec++; if (mem_rd !== exp_rd) begin n_err++; $display("FAIL rnd_issue: cyc %0d got %b want %b", cyc, mem_rd, exp_rd); end
                if (mem_rd) begin
                    n_vec++; if (mem_addr !== issue_ptr) begin n_err++; $display("FAIL rnd_addr: cyc %0d got %h want %h", cyc, mem_addr, issue_ptr); end
                    issue_ptr = issue_ptr + 16'h1;
                    wait_left = $urandom_range(0, 3);
                end
            end
            // Stimulus for the coming edge.
            if (mem_rd) begin
                mem_ack = (wait_left == 0);
                if (wait_left > 0) wait_left--;
                mem_rdata = memf(mem_addr);
            end else begin
                mem_ack = ($urandom_range(0, 9) == 0);
                mem_rdata = 16'($urandom());
            end
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom());
            if ($urandom_range(0, 19) == 0) halt = !halt;
            // Reference model update for the coming edge.
            if (redirect) begin
                mq.delete();
                stale = mem_rd && !mem_ack;
                issue_ptr = redirect_pc;
            end else begin
                if (mq.size() != 0 && instr_ready) void'(mq.pop_front());
                if (mem_rd && mem_ack) begin
                    if (stale) stale = 1'b0;
                    else mq.push_back({mem_rdata, mem_addr});
                end
            end
            prev_rd = mem_rd; prev_ack = mem_ack; prev_halt = halt; prev_addr = mem_addr;
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_ack();
        test_wrap();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
